// File: rtl/bus_slave_resp.sv
// Bus responder for the shared 32-bit two-master bus: seven R/W registers plus a
// read-only transaction counter, completed with a sel/ack handshake after WAIT_CYCLES wait states.
module bus_slave_resp #(
    parameter logic [7:0]  BASE_ADDR   = 8'h00,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s_sel,
    input  logic        s_wr,
    input  logic [7:0]  s_addr,
    input  logic [31:0] s_din,
    output logic [31:0] s_dout,
    output logic        s_ack
);

    typedef enum logic [1:0] {IDLE, WAIT, ACK, DONE} state_t;

    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t      state, next_state;
    logic [3:0]  wcnt;
    logic        wr_q;
    logic [2:0]  idx_q;
    logic [31:0] din_q;
    logic [31:0] regs [7];
    logic [31:0] count;
    logic        hit;
    logic        ack_d;
    logic [31:0] dout_d;

    assign hit = s_sel && (s_addr[7:3] == BASE_ADDR[7:3]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (hit) next_state = (WAIT_CYCLES == 0) ? ACK : WAIT;
            WAIT: begin
                if (!s_sel)          next_state = IDLE;
                else if (wcnt == '0) next_state = ACK;
            end
            ACK:  next_state = DONE;
            DONE: if (!s_sel) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The count read back is the pre-increment value because both update on the same edge.
    always_comb begin
        ack_d  = 1'b0;
        dout_d = '0;
        if (state == ACK) begin
            ack_d = 1'b1;
            if (!wr_q) dout_d = (idx_q == 3'd7) ? count : regs[idx_q];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all reads see pre-edge values.
    // NOTE: the register file is reset explicitly because reads after reset must return zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wcnt   <= '0;
            wr_q   <= 1'b0;
            idx_q  <= '0;
            din_q  <= '0;
            count  <= '0;
            s_ack  <= 1'b0;
            s_dout <= '0;
            for (int i = 0; i < 7; i++) regs[i] <= '0;
        end else begin
            s_ack  <= ack_d;
            s_dout <= dout_d;
            unique case (state)
                IDLE: begin
                    if (hit) begin
                        wr_q  <= s_wr;
                        idx_q <= s_addr[2:0];
                        din_q <= s_din;
                        wcnt  <= WAIT_INIT;
                    end
                end
                WAIT: begin
                    if (wcnt != '0) wcnt <= wcnt - 4'd1;
                end
                ACK: begin
                    if (wr_q && idx_q != 3'd7) regs[idx_q] <= din_q;
                    count <= count + 32'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
